// File: rtl/jarvis_sequencer_if.sv
// Control/status bundle between the instruction sequencer and its datapath.
// The datapath side (master) drives the handshake inputs.
// The sequencer side (slave) drives the strobes and the status outputs.
interface jarvis_sequencer_if;
  logic        start;
  logic        halt_req;
  logic [4:0]  op_code;
  logic        mem_ready;
  logic        branch_taken;
  logic        pc_write;
  logic        ir_write;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        reg_dest;
  logic        reg_write;
  logic        alu_src;
  logic [1:0]  alu_op;
  logic        busy;
  logic        illegal_op;
  logic        retire;
  logic [2:0]  state;
  logic [15:0] instr_count;

  modport master (
    output start, halt_req, op_code, mem_ready, branch_taken,
    input  pc_write, ir_write, mem_read, mem_write, mem_to_reg, reg_dest,
    input  reg_write, alu_src, alu_op, busy, illegal_op, retire, state, instr_count
  );

  modport slave (
    input  start, halt_req, op_code, mem_ready, branch_taken,
    output pc_write, ir_write, mem_read, mem_write, mem_to_reg, reg_dest,
    output reg_write, alu_src, alu_op, busy, illegal_op, retire, state, instr_count
  );
endinterface

// File: rtl/jarvis_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP.
// Optional retirement counter enabled by defining JARVIS_SEQ_PERF_EN;
// without it instr_count is constant 0 and no counter flops exist.
module jarvis_sequencer (
  input logic clk,
  input logic rst_n,
  jarvis_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd7
  } state_t;

  state_t      state_q;
  state_t      state_d;
  state_t      next_instr;
  logic [4:0]  ir_op;
  logic        halt_flag;
  logic [1:0]  rst_sync;
  logic        run;

  logic is_reg, is_imm, is_load, is_store, is_branch, is_jump, is_nop, is_undef;

  logic       pc_write, ir_write, mem_read, mem_write;
  logic       mem_to_reg, reg_dest, reg_write, alu_src;
  logic [1:0] alu_op;
  logic       illegal_op, retire;

  // Reset release is re-timed so the FSM only starts two edges after rst_n rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run = rst_sync[1];

  // Classify the latched opcode into its instruction class
  always_comb begin
    is_jump   = (ir_op == 5'b00100);
    is_nop    = (ir_op == 5'b11111);
    is_load   = (ir_op == 5'b00001);
    is_store  = (ir_op == 5'b00010);
    is_undef  = (ir_op >= 5'b10110) && (ir_op <= 5'b11110);
    is_branch = (ir_op >= 5'b01110) && (ir_op <= 5'b10011);
    is_reg    = ir_op inside {5'b00000, 5'b01001, 5'b01011, 5'b01101, 5'b10100, 5'b10101};
    is_imm    = ir_op inside {5'b00011, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01010, 5'b01100};
  end

  // A halt seen at any point of the current instruction parks the sequencer in IDLE
  assign next_instr = (halt_flag || bus.halt_req) ? IDLE : FETCH;

  // Next-state and strobe decode; only the FETCH/MEM handshake and branch result qualify strobes
  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_dest   = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    illegal_op = 1'b0;
    retire     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = FETCH;
      end
      FETCH: begin
        mem_read = 1'b1;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        if (is_jump) begin
          pc_write = 1'b1;
          retire   = 1'b1;
          state_d  = next_instr;
        end else if (is_nop) begin
          retire  = 1'b1;
          state_d = next_instr;
        end else if (is_undef) begin
          state_d = TRAP;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (is_reg) begin
          alu_op  = 2'b01;
          alu_src = (ir_op == 5'b10101);
          state_d = WB;
        end else if (is_imm) begin
          alu_op  = 2'b10;
          alu_src = 1'b1;
          state_d = WB;
        end else if (is_load || is_store) begin
          alu_op  = 2'b00;
          alu_src = 1'b1;
          state_d = MEM;
        end else begin
          alu_op   = 2'b10;
          pc_write = bus.branch_taken;
          retire   = 1'b1;
          state_d  = next_instr;
        end
      end
      MEM: begin
        mem_read  = is_load;
        mem_write = !is_load;
        if (bus.mem_ready) begin
          if (is_load) begin
            state_d = WB;
          end else begin
            retire  = 1'b1;
            state_d = next_instr;
          end
        end
      end
      WB: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        reg_dest   = is_reg;
        mem_to_reg = is_load;
        state_d    = next_instr;
      end
      TRAP: begin
        illegal_op = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register, instruction latch and sticky halt request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ir_op     <= 5'b11111;
      halt_flag <= 1'b0;
    end else if (run) begin
      state_q <= state_d;
      if (state_q == FETCH && bus.mem_ready) ir_op <= bus.op_code;
      if (state_d == FETCH && state_q != FETCH) halt_flag <= 1'b0;
      else if (bus.halt_req)                    halt_flag <= 1'b1;
    end
  end

`ifdef JARVIS_SEQ_PERF_EN
  logic [15:0] count_q;

  // Retired-instruction counter; retire is never high in IDLE/TRAP so it holds there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      count_q <= 16'd0;
    else if (retire) count_q <= count_q + 16'd1;
  end

  assign bus.instr_count = count_q;
`else
  assign bus.instr_count = 16'd0;
`endif

  assign bus.pc_write   = pc_write;
  assign bus.ir_write   = ir_write;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.reg_dest   = reg_dest;
  assign bus.reg_write  = reg_write;
  assign bus.alu_src    = alu_src;
  assign bus.alu_op     = alu_op;
  assign bus.illegal_op = illegal_op;
  assign bus.retire     = retire;
  assign bus.busy       = (state_q != IDLE) && (state_q != TRAP);
  assign bus.state      = state_q;

endmodule

// File: tb/tb_jarvis_sequencer.sv
// Randomised bench for jarvis_sequencer against an instruction-level reference model.
// The model expands each opcode into its list of phases and predicts every strobe per cycle.
module tb_jarvis_sequencer;

  localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3, P_MEM = 4, P_WB = 5, P_TRAP = 7;
  localparam int C_REG = 0, C_IMM = 1, C_LOAD = 2, C_STORE = 3, C_BRANCH = 4, C_JUMP = 5, C_NOP = 6, C_UNDEF = 7;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   model_count;
  bit   in_idle;

  jarvis_sequencer_if bus();

  jarvis_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Abort a stuck run instead of hanging
  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int op_class(input logic [4:0] op);
    if (op == 5'd4) return C_JUMP;
    if (op == 5'd31) return C_NOP;
    if (op >= 5'd22) return C_UNDEF;
    if (op >= 5'd14 && op <= 5'd19) return C_BRANCH;
    if (op == 5'd1) return C_LOAD;
    if (op == 5'd2) return C_STORE;
    if (op inside {5'd0, 5'd9, 5'd11, 5'd13, 5'd20, 5'd21}) return C_REG;
    return C_IMM;
  endfunction

  function automatic logic [12:0] observed_sig();
    return {bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write, bus.mem_to_reg,
            bus.reg_dest, bus.reg_write, bus.alu_src, bus.alu_op, bus.busy,
            bus.illegal_op, bus.retire};
  endfunction

  function automatic logic [12:0] expect_sig(input int phase, input int cls, input logic [4:0] op,
                                             input logic last, input logic taken);
    logic pc = 1'b0, ir = 1'b0, mr = 1'b0, mw = 1'b0, m2r = 1'b0, rd = 1'b0, rw = 1'b0, as = 1'b0;
    logic [1:0] ao = 2'b00;
    logic busy = 1'b0, ill = 1'b0, ret = 1'b0;
    case (phase)
      P_FETCH: begin mr = 1'b1; pc = last; ir = last; busy = 1'b1; end
      P_DECODE: begin
        busy = 1'b1;
        if (cls == C_JUMP) begin pc = 1'b1; ret = 1'b1; end
        if (cls == C_NOP) ret = 1'b1;
      end
      P_EXEC: begin
        busy = 1'b1;
        if (cls == C_REG) begin ao = 2'b01; as = (op == 5'd21); end
        if (cls == C_IMM) begin ao = 2'b10; as = 1'b1; end
        if (cls == C_LOAD || cls == C_STORE) begin ao = 2'b00; as = 1'b1; end
        if (cls == C_BRANCH) begin ao = 2'b10; pc = taken; ret = 1'b1; end
      end
      P_MEM: begin
        busy = 1'b1;
        if (cls == C_LOAD) mr = 1'b1;
        else begin mw = 1'b1; ret = last; end
      end
      P_WB: begin busy = 1'b1; rw = 1'b1; ret = 1'b1; rd = (cls == C_REG); m2r = (cls == C_LOAD); end
      P_TRAP: ill = 1'b1;
      default: ;
    endcase
    return {pc, ir, mr, mw, m2r, rd, rw, as, ao, busy, ill, ret};
  endfunction

  task automatic applyStimulus(input logic s, input logic h, input logic [4:0] op,
                               input logic mr, input logic bt);
    bus.start        = s;
    bus.halt_req     = h;
    bus.op_code      = op;
    bus.mem_ready    = mr;
    bus.branch_taken = bt;
  endtask

  task automatic checkCycle(input string tag, input int exp_state, input logic [12:0] exp_sig);
    logic [15:0] exp_cnt;
    @(negedge clk);
`ifdef JARVIS_SEQ_PERF_EN
    exp_cnt = model_count[15:0];
`else
    exp_cnt = 16'd0;
`endif
    checkOutput({tag, "/state"}, 32'(bus.state), 32'(exp_state));
    checkOutput({tag, "/strobes"}, 32'(observed_sig()), 32'(exp_sig));
    checkOutput({tag, "/count"}, 32'(bus.instr_count), 32'(exp_cnt));
    if (exp_sig[0]) model_count++;
    @(posedge clk);
    #1;
  endtask

  task automatic finishReset();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) checkCycle("post_reset", P_IDLE, 13'd0);
    in_idle = 1'b1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    model_count = 0;
    #1;
    checkOutput("reset/state", 32'(bus.state), 32'd0);
    checkOutput("reset/strobes", 32'(observed_sig()), 32'd0);
    checkOutput("reset/count", 32'(bus.instr_count), 32'd0);
    finishReset();
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b0, 1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
      checkCycle("idle", P_IDLE, 13'd0);
    end
  endtask

  task automatic runInstr(input logic [4:0] op, input int fetch_wait, input int mem_wait,
                          input logic taken, input int halt_at, input int abort_at);
    int   path[$];
    int   cls;
    int   cyc;
    int   n;
    bit   halted;
    logic last, h, mr, bt;
    logic [4:0] opin;
    string tag;
    cls = op_class(op);
    cyc = 0;
    halted = 1'b0;
    path.push_back(P_FETCH);
    path.push_back(P_DECODE);
    if (cls inside {C_REG, C_IMM, C_LOAD, C_STORE, C_BRANCH}) path.push_back(P_EXEC);
    if (cls inside {C_LOAD, C_STORE}) path.push_back(P_MEM);
    if (cls inside {C_REG, C_IMM, C_LOAD}) path.push_back(P_WB);
    if (in_idle) begin
      applyStimulus(1'b1, 1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
      checkCycle("idle_start", P_IDLE, 13'd0);
      in_idle = 1'b0;
    end
    foreach (path[p]) begin
      n = (path[p] == P_FETCH) ? fetch_wait + 1 : (path[p] == P_MEM) ? mem_wait + 1 : 1;
      for (int k = 0; k < n; k++) begin
        last = (k == n - 1);
        h    = (cyc == halt_at);
        mr   = (path[p] == P_FETCH || path[p] == P_MEM) ? last : 1'($urandom);
        opin = (path[p] == P_FETCH && last) ? op : 5'($urandom);
        bt   = (path[p] == P_EXEC) ? taken : 1'($urandom);
        applyStimulus(1'($urandom), h, opin, mr, bt);
        halted = halted || h;
        tag = $sformatf("op%0d/c%0d", op, cyc);
        if (cyc == abort_at) begin
          #2;
          rst_n = 1'b0;
          model_count = 0;
          #1;
          checkOutput({tag, "/abort_state"}, 32'(bus.state), 32'd0);
          checkOutput({tag, "/abort_strobes"}, 32'(observed_sig()), 32'd0);
          checkOutput({tag, "/abort_count"}, 32'(bus.instr_count), 32'd0);
          finishReset();
          return;
        end
        checkCycle(tag, path[p], expect_sig(path[p], cls, op, last, taken));
        cyc++;
      end
    end
    if (cls == C_UNDEF) begin
      for (int k = 0; k < 4; k++) begin
        applyStimulus(1'(k % 2 == 0), 1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
        checkCycle($sformatf("trap%0d", k), P_TRAP, expect_sig(P_TRAP, cls, op, 1'b1, 1'b0));
      end
      doReset();
      return;
    end
    in_idle = halted;
  endtask

  // Directed scenarios first, then a randomised instruction stream
  initial begin
    logic [4:0] rop;
    int   hat;
    int   abt;
    bit   seen;
    total = 0;
    bad = 0;
    model_count = 0;
    in_idle = 1'b1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    #3;
    doReset();
    idleCycles(2);

    rst_n = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 5'd31, 1'b1, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("release/edge0", 32'(bus.state), 32'd0);
    @(negedge clk);
    checkOutput("release/edge1", 32'(bus.state), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      @(negedge clk);
      if (bus.state == 3'd1) seen = 1'b1;
    end
    checkOutput("release/fetch_reached", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    doReset();

    runInstr(5'd0, 0, 0, 1'b0, -1, -1);
    runInstr(5'd1, 1, 3, 1'b0, -1, -1);
    runInstr(5'd14, 0, 0, 1'b1, -1, -1);
    runInstr(5'd14, 0, 0, 1'b0, -1, -1);
    runInstr(5'd21, 0, 0, 1'b0, -1, -1);
    runInstr(5'd2, 0, 2, 1'b0, -1, -1);
    runInstr(5'd4, 0, 0, 1'b0, -1, -1);
    runInstr(5'd31, 0, 0, 1'b0, -1, -1);
    runInstr(5'd5, 0, 0, 1'b0, 0, -1);
    idleCycles(2);
    runInstr(5'd23, 0, 0, 1'b0, -1, -1);
    runInstr(5'd0, 3, 0, 1'b0, -1, 1);
    runInstr(5'd2, 0, 4, 1'b0, -1, 5);
    runInstr(5'd1, 0, 4, 1'b0, -1, 4);

    for (int n = 0; n < 250; n++) begin
      rop = 5'($urandom);
      hat = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 4)) : -1;
      abt = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 3)) : -1;
      runInstr(rop, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom), hat, abt);
      if (in_idle && $urandom_range(0, 1) == 1) idleCycles($urandom_range(1, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
